// File: rtl/matrix_pkg.sv
// Shared types and helpers for the 8x8 LED matrix scan interface.
// Used by both the matrix controller and the scan decoder.
package matrix_pkg;

  localparam int MATRIX_ROWS = 8;
  localparam int MATRIX_COLS = 8;
  localparam int FRAME_W     = MATRIX_ROWS * MATRIX_COLS;

  typedef logic [MATRIX_ROWS-1:0] row_sel_t;
  typedef logic [MATRIX_COLS-1:0] col_data_t;
  typedef logic [FRAME_W-1:0]     frame_t;

  typedef struct packed {
    logic       valid;
    logic [2:0] idx;
  } onehot_res_t;

  // valid is set only when exactly one select bit is high
  function automatic onehot_res_t onehot_index(input row_sel_t sel);
    onehot_res_t res;
    int unsigned ones;
    res  = '0;
    ones = 0;
    for (int i = 0; i < MATRIX_ROWS; i++) begin
      if (sel[i]) begin
        ones++;
        res.idx = 3'(i);
      end
    end
    res.valid = (ones == 1);
    return res;
  endfunction

endpackage

// File: rtl/scan_stability_filter.sv
// Synchronises row/column lines and emits one capture strobe per stable dwell.
// The strobe and the captured row/column are registered.
module scan_stability_filter
  import matrix_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int SYNC_STAGES   = 2
) (
  input  logic      clk,
  input  logic      rst,
  input  row_sel_t  row_i,
  input  col_data_t col_i,
  output logic      capture_o,
  output row_sel_t  cap_row_o,
  output col_data_t cap_col_o
);

  localparam int PW = MATRIX_ROWS + MATRIX_COLS;
  localparam logic [7:0] STABLE_MAX = 8'(STABLE_CYCLES);
  localparam logic [7:0] STABLE_M1  = 8'(STABLE_CYCLES - 1);

  logic [PW-1:0] pins;
  logic [PW-1:0] synced;

  assign pins = {row_i, col_i};

  generate
    if (SYNC_STAGES == 0) begin : g_bypass
      assign synced = pins;
    end else begin : g_sync
      logic [PW-1:0] sync_q [SYNC_STAGES];
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
          sync_q[0] <= pins;
          for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
      end
      assign synced = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  logic [PW-1:0] prev_q;
  logic [7:0]    cnt_q, cnt_d;
  logic          captured_q, captured_d;
  logic          capture_q;
  row_sel_t      cap_row_q;
  col_data_t     cap_col_q;
  logic          changed, fire;

  // The cycle in which the pair changes counts as the first cycle of its dwell
  always_comb begin
    changed    = (synced != prev_q);
    cnt_d      = cnt_q;
    captured_d = changed ? 1'b0 : captured_q;
    if (changed) begin
      cnt_d = '0;
    end else if (cnt_q < STABLE_MAX) begin
      cnt_d = cnt_q + 8'd1;
    end
    fire       = (cnt_d == STABLE_M1) && !captured_d;
    captured_d = captured_d | fire;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q     <= '0;
      cnt_q      <= '0;
      captured_q <= 1'b0;
      capture_q  <= 1'b0;
      cap_row_q  <= '0;
      cap_col_q  <= '0;
    end else begin
      prev_q     <= synced;
      cnt_q      <= cnt_d;
      captured_q <= captured_d;
      capture_q  <= fire;
      if (fire) begin
        cap_row_q <= synced[PW-1 -: MATRIX_ROWS];
        cap_col_q <= synced[MATRIX_COLS-1:0];
      end
    end
  end

  assign capture_o = capture_q;
  assign cap_row_o = cap_row_q;
  assign cap_col_o = cap_col_q;

endmodule

// File: rtl/matrix_scan_decoder.sv
// Rebuilds 64-bit frames from the LED matrix row/column scan and flags protocol errors.
// Optional error counter (err_count/err_clr) is built when SCAN_ERR_COUNT_EN is defined.
module matrix_scan_decoder
  import matrix_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int SYNC_STAGES   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  row_in,
  input  logic [7:0]  col_in,
  output logic [63:0] frame_out,
  output logic        frame_valid,
  output logic        scan_err,
  output logic [15:0] frame_count,
  output logic [2:0]  cur_row
`ifdef SCAN_ERR_COUNT_EN
  ,
  output logic [7:0]  err_count,
  input  logic        err_clr
`endif
);

  localparam logic [2:0] ROW_LAST = 3'(MATRIX_ROWS - 1);

  logic      capture;
  row_sel_t  cap_row;
  col_data_t cap_col;

  scan_stability_filter #(
    .STABLE_CYCLES(STABLE_CYCLES),
    .SYNC_STAGES  (SYNC_STAGES)
  ) u_filter (
    .clk      (clk),
    .rst      (rst),
    .row_i    (row_in),
    .col_i    (col_in),
    .capture_o(capture),
    .cap_row_o(cap_row),
    .cap_col_o(cap_col)
  );

  frame_t      shadow_q, shadow_d, frame_q, frame_d;
  logic        valid_q, valid_d, err_q, err_d;
  logic [15:0] count_q, count_d;
  logic [2:0]  row_q, row_d;
  onehot_res_t oh;

  always_comb begin
    oh       = onehot_index(cap_row);
    shadow_d = shadow_q;
    frame_d  = frame_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;
    count_d  = count_q;
    row_d    = row_q;
    if (capture && (cap_row != '0)) begin
      if (!oh.valid) begin
        err_d = 1'b1;
        row_d = '0;
      end else if (oh.idx == row_q) begin
        shadow_d[{oh.idx, 3'b000} +: 8] = cap_col;
        if (oh.idx == ROW_LAST) begin
          // Final row goes straight into frame_out so it is never seen half-built
          frame_d = {cap_col, shadow_q[FRAME_W-MATRIX_COLS-1:0]};
          valid_d = 1'b1;
          count_d = count_q + 16'd1;
          row_d   = '0;
        end else begin
          row_d = oh.idx + 3'd1;
        end
      end else if (oh.idx == 3'd0) begin
        shadow_d[7:0] = cap_col;
        row_d         = 3'd1;
        err_d         = (row_q != 3'd0);
      end else begin
        err_d = 1'b1;
        row_d = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q <= '0;
      frame_q  <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      count_q  <= '0;
      row_q    <= '0;
    end else begin
      shadow_q <= shadow_d;
      frame_q  <= frame_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      count_q  <= count_d;
      row_q    <= row_d;
    end
  end

  assign frame_out   = frame_q;
  assign frame_valid = valid_q;
  assign scan_err    = err_q;
  assign frame_count = count_q;
  assign cur_row     = row_q;

`ifdef SCAN_ERR_COUNT_EN
  logic [7:0] err_cnt_q;

  // Clear wins over a coincident error pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else if (err_clr) begin
      err_cnt_q <= '0;
    end else if (err_q && (err_cnt_q != 8'hFF)) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_matrix_scan_decoder.sv
// Directed bench for matrix_scan_decoder; exercises SCAN_ERR_COUNT_EN when defined.
`timescale 1ns/1ps
module tb_matrix_scan_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  row_in = '0;
  logic [7:0]  col_in = '0;
  logic [63:0] frame_out;
  logic        frame_valid, scan_err;
  logic [15:0] frame_count;
  logic [2:0]  cur_row;
`ifdef SCAN_ERR_COUNT_EN
  logic [7:0]  err_count;
  logic        err_clr = 1'b0;
`endif

  int checks = 0;
  int failures = 0;
  int fv_seen = 0;
  int err_seen = 0;
  int fv0, err0;

  always #5 clk = ~clk;

  matrix_scan_decoder #(.STABLE_CYCLES(4), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .row_in     (row_in),
    .col_in     (col_in),
    .frame_out  (frame_out),
    .frame_valid(frame_valid),
    .scan_err   (scan_err),
    .frame_count(frame_count),
    .cur_row    (cur_row)
`ifdef SCAN_ERR_COUNT_EN
    ,
    .err_count  (err_count),
    .err_clr    (err_clr)
`endif
  );

  always @(negedge clk) begin
    if (!rst) begin
      if (frame_valid) fv_seen++;
      if (scan_err) err_seen++;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic hold(input logic [7:0] r, input logic [7:0] c, input int n);
    row_in = r;
    col_in = c;
    repeat (n) @(negedge clk);
  endtask

  task automatic scan_rows(input logic [63:0] f, input int first, input int last, input int blank);
    for (int r = first; r <= last; r++) begin
      hold(8'(1 << r), f[r*8 +: 8], 10);
      if (blank > 0) hold(8'h00, 8'h00, blank);
    end
    hold(8'h00, 8'h00, 10);
  endtask

  task automatic snap();
    fv0  = fv_seen;
    err0 = err_seen;
  endtask

  localparam logic [63:0] F1 = 64'h0123456789ABCDEF;
  localparam logic [63:0] F2 = 64'hFEDCBA9876543210;
  localparam logic [63:0] F3 = 64'h1122334455667788;
  localparam logic [63:0] F4 = 64'hA5A55A5A0F0FF0F0;
  localparam logic [63:0] F5 = 64'h8040201008040201;
  localparam logic [63:0] F6 = 64'h00FF00FF12345678;
  localparam logic [63:0] F7 = 64'hDEADBEEFCAFEF00D;

  initial begin
    repeat (3) @(negedge clk);
    check_eq("reset_frame_out", frame_out, 64'h0);
    check_eq("reset_frame_valid", frame_valid, 0);
    check_eq("reset_scan_err", scan_err, 0);
    check_eq("reset_frame_count", frame_count, 0);
    check_eq("reset_cur_row", cur_row, 0);
    rst = 1'b0;
    hold(8'h00, 8'h00, 5);

    snap();
    scan_rows(F1, 0, 7, 0);
    check_eq("clean_frame_out", frame_out, F1);
    check_eq("clean_valid_pulses", fv_seen - fv0, 1);
    check_eq("clean_count", frame_count, 1);
    check_eq("clean_errors", err_seen - err0, 0);
    check_eq("clean_cur_row", cur_row, 0);

    snap();
    scan_rows(F2, 0, 7, 3);
    check_eq("blank_frame_out", frame_out, F2);
    check_eq("blank_valid_pulses", fv_seen - fv0, 1);
    check_eq("blank_errors", err_seen - err0, 0);
    check_eq("blank_count", frame_count, 2);

    snap();
    hold(8'h01, F3[7:0], 10);
    hold(8'h02, F3[15:8], 10);
    hold(8'h04, 8'hAA, 3);
    scan_rows(F3, 2, 7, 0);
    check_eq("glitch_frame_out", frame_out, F3);
    check_eq("glitch_errors", err_seen - err0, 0);
    check_eq("glitch_count", frame_count, 3);

    snap();
    for (int r = 0; r <= 3; r++) hold(8'(1 << r), F4[r*8 +: 8], 10);
    check_eq("illegal_pre_cur_row", cur_row, 4);
    hold(8'h06, 8'h3C, 10);
    hold(8'h00, 8'h00, 10);
    check_eq("illegal_err_pulses", err_seen - err0, 1);
    check_eq("illegal_cur_row", cur_row, 0);
    check_eq("illegal_frame_kept", frame_out, F3);
    check_eq("illegal_no_valid", fv_seen - fv0, 0);
    scan_rows(F4, 0, 7, 0);
    check_eq("illegal_next_frame", frame_out, F4);
    check_eq("illegal_no_more_err", err_seen - err0, 1);
    check_eq("illegal_count", frame_count, 4);

    snap();
    hold(8'h01, F5[7:0], 10);
    hold(8'h02, F5[15:8], 10);
    hold(8'h08, F5[31:24], 10);
    hold(8'h00, 8'h00, 10);
    check_eq("skip_err_pulses", err_seen - err0, 1);
    check_eq("skip_cur_row", cur_row, 0);
    scan_rows(F5, 0, 7, 0);
    check_eq("skip_resync_frame", frame_out, F5);
    check_eq("skip_valid_pulses", fv_seen - fv0, 1);
    check_eq("skip_count", frame_count, 5);

    snap();
    hold(8'h01, 8'h77, 10);
    hold(8'h00, 8'h00, 3);
    hold(8'h01, F7[7:0], 10);
    hold(8'h00, 8'h00, 10);
    check_eq("repeat_err_pulses", err_seen - err0, 1);
    check_eq("repeat_cur_row", cur_row, 1);
    scan_rows(F7, 1, 7, 0);
    check_eq("repeat_frame_out", frame_out, F7);
    check_eq("repeat_count", frame_count, 6);

    for (int r = 0; r <= 3; r++) hold(8'(1 << r), F6[r*8 +: 8], 10);
    hold(8'h10, F6[39:32], 3);
    #2 rst = 1'b1;
    #1;
    check_eq("async_rst_frame_out", frame_out, 64'h0);
    check_eq("async_rst_count", frame_count, 0);
    check_eq("async_rst_cur_row", cur_row, 0);
    check_eq("async_rst_valid_err", {frame_valid, scan_err}, 0);
    row_in = 8'h00;
    col_in = 8'h00;
    repeat (3) @(negedge clk);
    check_eq("rst_held_cur_row", cur_row, 0);
    rst = 1'b0;
    hold(8'h00, 8'h00, 5);
    snap();
    scan_rows(F6, 0, 7, 0);
    check_eq("post_rst_frame", frame_out, F6);
    check_eq("post_rst_count", frame_count, 1);
    check_eq("post_rst_errors", err_seen - err0, 0);

`ifdef SCAN_ERR_COUNT_EN
    check_eq("errcnt_after_rst", err_count, 0);
    snap();
    for (int i = 0; i < 300; i++) hold((i % 2 == 0) ? 8'h03 : 8'h05, 8'h00, 6);
    hold(8'h00, 8'h00, 10);
    check_eq("errcnt_pulses", err_seen - err0, 300);
    check_eq("errcnt_saturated", err_count, 255);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check_eq("errcnt_cleared", err_count, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/matrix_scan_decoder.md
Name: matrix_scan_decoder

Overview:
Receiving end of the 8x8 LED matrix row/column scan interface.
- Samples the row-select and column-data lines that the matrix controller drives.
- Rebuilds the 64-bit display frame they carry and flags scan-protocol violations.
- Used as an on-board monitor and self-check: it feeds frames back to the game logic or a debug readout, and serves as the scoreboard front-end in benches.

Parameters:
STABLE_CYCLES, 4, clk cycles a row/column pair must hold unchanged before it is captured (legal range 1..255)
SYNC_STAGES, 2, input synchroniser depth on row_in/col_in (legal range 0..3; 0 = bypass)

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
row_in  input  8  row select from matrix scan; one-hot active-high; bit r = row r; all-zero = blank
col_in  input  8  column data for the selected row; bit c = 1 means LED (r,c) lit
frame_out  output  64  last complete frame; bit r*8+c = LED (r,c)
frame_valid  output  1  one-cycle pulse when frame_out updates
scan_err  output  1  one-cycle pulse on a protocol violation
frame_count  output  16  number of completed frames, wraps 0xFFFF->0
cur_row  output  3  next row index expected

Behaviour:
- Reset (asynchronous, any cycle, including mid-frame): frame_out=0, frame_valid=0, scan_err=0, frame_count=0, cur_row=0, shadow buffer=0, stability counter=0, captured flag=0.
- Synchroniser: row_in/col_in pass through SYNC_STAGES flops. All timing below counts from the synchronised values (rs, cs).
- Stability counter:
  - Cleared when {rs,cs} differs from its value in the previous cycle; otherwise increments, saturating at STABLE_CYCLES.
  - A capture event fires in the cycle the counter reaches STABLE_CYCLES-1 with captured=0. captured is then set; it clears on the next change of {rs,cs}.
  - A dwell therefore captures at most once, however long it lasts.
- Classification at a capture event:
  - rs==0: blank. No action, no error. cur_row is kept (blanking between rows is legal).
  - rs not one-hot and not zero: scan_err pulse; frame aborted; cur_row=0.
  - One-hot rs with index r, r==cur_row: shadow[r*8+:8]=cs; cur_row=r+1.
  - One-hot rs with index r, r!=cur_row, r==0: resync. Shadow row 0=cs; cur_row=1; scan_err pulse only if cur_row was nonzero (partial frame lost).
  - One-hot rs with index r, r!=cur_row, r!=0: scan_err pulse; frame aborted; cur_row=0; the row is discarded.
- Frame completion:
  - Triggered by a capture of r==7 while cur_row==7.
  - Next edge: frame_out = shadow with row 7 = cs; frame_valid=1 for one cycle; frame_count+1; cur_row=0.
- Latency: pin change to capture = SYNC_STAGES + STABLE_CYCLES cycles; capture to frame_valid = 1 cycle.
- frame_out holds between frames and is never partially updated. An aborted frame leaves the previous frame_out intact.
- The same row repeated after a blank is a mismatch (r != cur_row) and is handled as above.
- Outputs frame_valid, scan_err and cur_row are registered.

Optional Feature:
SCAN_ERR_COUNT_EN
- Defined: adds output err_count (8 bits), reset 0. It increments on every scan_err pulse and saturates at 255. Adds input err_clr (1 bit); err_clr=1 clears err_count on the next edge, and clear takes priority over a simultaneous increment.
- Undefined: neither port exists and there is no counter logic. All other behaviour is identical.

Decomposition:
- Shared package matrix_pkg:
  - constants MATRIX_ROWS=8, MATRIX_COLS=8, FRAME_W=64;
  - typedef row_sel_t (8 bits), col_data_t (8 bits), frame_t (64 bits);
  - function onehot_index (returns a 3-bit index plus a valid flag).
  - The matrix controller reuses this package.
- One sub-module: scan_stability_filter. It contains the synchroniser, stability counter and captured flag, and outputs a single capture strobe plus the captured row/column. The parent holds the sequencing and the frame buffer.

Test Plan:
- Clean scan, frame 0x0123456789ABCDEF: rows 0..7 each held 10 cycles -> one frame_valid; frame_out=0x0123456789ABCDEF; frame_count=1; scan_err never asserts.
- Blanking: rows 0..7 each separated by 3 cycles of row_in=0 -> identical frame; no scan_err.
- Glitch: row 2 dwell of STABLE_CYCLES-1 cycles, then row 2 held steadily -> single capture; frame completes normally.
- Illegal select: row_in=0x06 held 10 cycles after row 3 -> scan_err pulse; cur_row=0; frame_out unchanged. The following full scan 0..7 completes with no further error.
- Skip and resync: rows 0,1,3 -> scan_err at row 3. Then rows 0..7 -> frame_valid, with frame_count incremented by exactly 1.
- Async reset asserted mid-frame at row 4, then a full scan -> all outputs 0 during reset; the first frame after release is correct. With SCAN_ERR_COUNT_EN, 300 errors -> err_count=255, and err_clr -> 0.
